setcc_arbiter: RTL and testbench

SETCC_ARBITER -- requirements
Module: setcc_arbiter

---
 rtl/setcc_pkg.sv | 21 ++
 rtl/setcc_compare.sv | 29 ++
 rtl/setcc_arbiter.sv | 120 ++++++++++++
 tb/tb_setcc_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/setcc_pkg.sv
// Shared definitions for the set-condition arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: 3-bit condition-code constants and the arbiter FSM state enum.
package setcc_pkg;

   // Unsigned comparisons of A against B; 3'b110 and 3'b111 are reserved.
   localparam logic [2:0] CC_LE = 3'b000;
   localparam logic [2:0] CC_LT = 3'b001;
   localparam logic [2:0] CC_GE = 3'b010;
   localparam logic [2:0] CC_GT = 3'b011;
   localparam logic [2:0] CC_EQ = 3'b100;
   localparam logic [2:0] CC_NE = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/setcc_compare.sv
// Unsigned set-condition comparator: c = (a <code> b); reserved codes give 0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (WIDTH) operands; code (3) condition code; c (1) condition result.
module setcc_compare
   import setcc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       code,
   output logic             c
);

   always_comb begin
      c = 1'b0;
      case (code)
         CC_LE:   c = (a <= b);
         CC_LT:   c = (a <  b);
         CC_GE:   c = (a >= b);
         CC_GT:   c = (a >  b);
         CC_EQ:   c = (a == b);
         CC_NE:   c = (a != b);
         default: c = 1'b0;
      endcase
   end

endmodule

// File: rtl/setcc_arbiter.sv
// Two-requester round-robin arbiter in front of one shared set-condition unit.
// Latency: grant in cycle N, rsp_valid in N+2; one operation per 3 cycles at best.
// Backpressure: rsp_c/rsp_id held while rsp_ready is low; no grants until the response transfers.
// Ports: clk, rst (async, active-high); reqN_valid/reqN_ready/reqN_a/reqN_b/reqN_code per requester;
//        rsp_valid/rsp_ready handshake, rsp_c (zero-extended condition), rsp_id (owning requester).
module setcc_arbiter
   import setcc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_code,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_code,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_c,
   output logic             rsp_id
);

   state_t           state_q, state_d;
   logic             last_grant_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       code_q;
   logic             id_q;
   logic [WIDTH-1:0] rsp_c_q;
   logic             rsp_id_q;

   logic             grant_vld;
   logic             grant_id;
   logic             cmp_c;

   // Next state, grant and ready. Ready is gated with rst because state_q
   // already reads IDLE during reset and must not leak a grant.
   always_comb begin
      state_d    = state_q;
      grant_vld  = 1'b0;
      grant_id   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               grant_vld = 1'b1;
               // Contention goes to whoever did not win last; otherwise the sole requester.
               if (req0_valid && req1_valid) begin
                  grant_id = ~last_grant_q;
               end else begin
                  grant_id = req1_valid;
               end
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            // No grant here: the completing transfer cycle only returns to IDLE.
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Comparator sees only captured operands, so requester inputs may change
   // freely after the grant.
   setcc_compare #(
      .WIDTH (WIDTH)
   ) u_compare (
      .a    (a_q),
      .b    (b_q),
      .code (code_q),
      .c    (cmp_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         code_q       <= 3'b000;
         id_q         <= 1'b0;
         rsp_c_q      <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_vld) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            a_q          <= grant_id ? req1_a    : req0_a;
            b_q          <= grant_id ? req1_b    : req0_b;
            code_q       <= grant_id ? req1_code : req0_code;
         end
         if (state_q == S_EXEC) begin
            rsp_c_q  <= {{(WIDTH-1){1'b0}}, cmp_c};
            rsp_id_q <= id_q;
         end
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_c     = rsp_c_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_setcc_arbiter.sv
// Scoreboard bench for setcc_arbiter: directed scenarios followed by random traffic.
module tb_setcc_arbiter;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   code;
   } op_t;

   typedef struct {
      logic [W-1:0] c;
      logic         id;
      int           gcyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]   req0_code = 3'b0, req1_code = 3'b0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_c;
   logic         rsp_id;

   setcc_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_code  (req0_code),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_code  (req1_code),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_c      (rsp_c),
      .rsp_id     (rsp_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: unsigned comparison selected by code, result in bit 0.
   function automatic logic [W-1:0] ref_setcc(input op_t op);
      logic t;
      case (op.code)
         3'd0:    t = (op.a <= op.b);
         3'd1:    t = (op.a <  op.b);
         3'd2:    t = (op.a >= op.b);
         3'd3:    t = (op.a >  op.b);
         3'd4:    t = (op.a == op.b);
         3'd5:    t = (op.a != op.b);
         default: t = 1'b0;
      endcase
      return {{(W-1){1'b0}}, t};
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.a = W'($urandom);
      if ($urandom_range(0, 5) == 0) o.a = 16'h8000;
      case ($urandom_range(0, 3))
         0:       o.b = o.a;
         1:       o.b = o.a + 16'd1;
         2:       o.b = o.a - 16'd1;
         default: o.b = W'($urandom);
      endcase
      o.code = 3'($urandom_range(0, 7));
      return o;
   endfunction

   // ---------------- driver ----------------
   op_t q0[$], q1[$];
   bit  hs0, hs1;
   bit  allow_drop = 0, toggle = 0, rand_rdy = 0;
   int  hold_cnt = 0;

   always begin
      op_t o;
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0 || !req0_valid) begin
         if (q0.size() > 0) begin
            o = q0.pop_front();
            req0_valid = 1'b1; req0_a = o.a; req0_b = o.b; req0_code = o.code;
         end else begin
            req0_valid = 1'b0;
            if (toggle) begin o = rand_op(); req0_a = o.a; req0_b = o.b; req0_code = o.code; end
         end
      end else if (allow_drop && $urandom_range(0, 15) == 0) begin
         req0_valid = 1'b0;
      end else if (toggle) begin
         o = rand_op(); req0_a = o.a; req0_b = o.b; req0_code = o.code;
      end
      if (hs1 || !req1_valid) begin
         if (q1.size() > 0) begin
            o = q1.pop_front();
            req1_valid = 1'b1; req1_a = o.a; req1_b = o.b; req1_code = o.code;
         end else begin
            req1_valid = 1'b0;
            if (toggle) begin o = rand_op(); req1_a = o.a; req1_b = o.b; req1_code = o.code; end
         end
      end else if (allow_drop && $urandom_range(0, 15) == 0) begin
         req1_valid = 1'b0;
      end else if (toggle) begin
         o = rand_op(); req1_a = o.a; req1_b = o.b; req1_code = o.code;
      end
      if (hold_cnt > 0) begin
         rsp_ready = 1'b0;
         hold_cnt--;
      end else if (rand_rdy) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
         rsp_ready = 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   exp_t         sb[$];
   bit           m_idle = 1, m_last = 1;
   bit           prev_vld = 0;
   logic [W-1:0] prev_c;
   logic         prev_id;

   always @(negedge clk) begin
      bit   er0, er1;
      exp_t e;
      op_t  o;
      if (rst) begin
         m_idle = 1; m_last = 1; sb.delete(); prev_vld = 0;
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_c", rsp_c, 0);
         check("rst_rsp_id", rsp_id, 0);
         check("rst_readies", {req1_ready, req0_ready}, 0);
      end else begin
         er0 = m_idle && req0_valid && (!req1_valid || m_last);
         er1 = m_idle && req1_valid && (!req0_valid || !m_last);
         check("req0_ready", req0_ready, er0);
         check("req1_ready", req1_ready, er1);
         if (req0_valid && req0_ready) begin
            o = '{a: req0_a, b: req0_b, code: req0_code};
            e.c = ref_setcc(o); e.id = 1'b0; e.gcyc = cyc;
            sb.push_back(e); m_last = 0; m_idle = 0;
         end else if (req1_valid && req1_ready) begin
            o = '{a: req1_a, b: req1_b, code: req1_code};
            e.c = ref_setcc(o); e.id = 1'b1; e.gcyc = cyc;
            sb.push_back(e); m_last = 1; m_idle = 0;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("spurious_rsp_valid", rsp_valid, 0);
            end else begin
               if (!prev_vld) check("rsp_latency", cyc - sb[0].gcyc, 2);
               else begin
                  check("rsp_c_stable", rsp_c, prev_c);
                  check("rsp_id_stable", rsp_id, prev_id);
               end
               if (rsp_ready) begin
                  check("rsp_c", rsp_c, sb[0].c);
                  check("rsp_id", rsp_id, sb[0].id);
                  void'(sb.pop_front());
                  m_idle = 1;
               end
            end
         end else if (sb.size() > 0 && cyc >= sb[0].gcyc + 2) begin
            check("rsp_valid_missing", rsp_valid, 1);
         end
         prev_vld = rsp_valid && !rsp_ready;
         prev_c   = rsp_c;
         prev_id  = rsp_id;
      end
   end

   // ---------------- sequencing ----------------
   task automatic wait_drain(input string name);
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
               m_idle && sb.size() == 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check(name, (n < 3000) ? 1 : 0, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Single requester, unsigned less-than.
      q0.push_back('{a: 16'd5, b: 16'd9, code: 3'b001});
      wait_drain("drain_single");

      // Contention straight after reset: req0 first, then req1.
      do_reset();
      q0.push_back('{a: 16'h1234, b: 16'h1234, code: 3'b100});
      q1.push_back('{a: 16'hFFFF, b: 16'h0001, code: 3'b011});
      wait_drain("drain_contention");

      // Reserved codes and the unsigned sign-bit case.
      q0.push_back('{a: 16'd3, b: 16'd3, code: 3'b110});
      q0.push_back('{a: 16'd3, b: 16'd3, code: 3'b111});
      q1.push_back('{a: 16'd3, b: 16'd3, code: 3'b110});
      q1.push_back('{a: 16'h8000, b: 16'h0001, code: 3'b001});
      wait_drain("drain_reserved");

      // Response held off while requester inputs churn.
      toggle = 1;
      hold_cnt = 9;
      q0.push_back('{a: 16'd7, b: 16'd7, code: 3'b010});
      q1.push_back('{a: 16'd1, b: 16'd2, code: 3'b011});
      wait_drain("drain_backpressure");
      toggle = 0;

      // Reset while the granted operation is in EXEC.
      q1.push_back('{a: 16'd1, b: 16'd2, code: 3'b001});
      n = 0;
      while (m_idle && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("exec_grant_seen", m_idle ? 0 : 1, 1);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      q0.push_back('{a: 16'd9, b: 16'd9, code: 3'b000});
      q1.push_back('{a: 16'd9, b: 16'd8, code: 3'b011});
      wait_drain("drain_after_exec_reset");

      // Random traffic with drops, toggling operands and random rsp_ready.
      rand_rdy = 1; allow_drop = 1; toggle = 1;
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #2;
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      end
      allow_drop = 0;
      wait_drain("drain_random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
